// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller.
package mem_bist_pkg;

    // Controller phases: background write, ascending read/invert, descending read.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BG   = 3'd1,
        RD_INV  = 3'd2,
        RD_DESC = 3'd3,
        DONE    = 3'd4
    } bist_state_e;

    // Default background word: odd bits set.
    localparam logic [13:0] DEFAULT_PATTERN = 14'h2AAA;

endpackage : mem_bist_pkg

// File: rtl/mem_bist_cmp.sv
// Read-data comparator with first-fail capture for the memory BIST controller.
// A mismatch is flagged combinationally so the controller can react on the
// same edge at which the failing word is captured.
module mem_bist_cmp
    import mem_bist_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 cmp_en,
    input  logic [ADDR_BITS-1:0] cmp_addr,
    input  logic [DATA_BITS-1:0] cmp_expected,
    input  logic [DATA_BITS-1:0] rdata,
    output logic                 mismatch,
    output logic                 pass,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [DATA_BITS-1:0] fail_expected,
    output logic [DATA_BITS-1:0] fail_actual
);

    logic                 pass_r;
    logic [ADDR_BITS-1:0] fail_addr_r;
    logic [DATA_BITS-1:0] fail_expected_r;
    logic [DATA_BITS-1:0] fail_actual_r;
    logic                 mismatch_s;

    // Miscompare on the current compare slot.
    always_comb begin
        mismatch_s = 1'b0;
        if (cmp_en) begin
            mismatch_s = (rdata != cmp_expected);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Capture only the first miscompare of a run; a new run clears the record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_r          <= 1'b1;
            fail_addr_r     <= {ADDR_BITS{1'b0}};
            fail_expected_r <= {DATA_BITS{1'b0}};
            fail_actual_r   <= {DATA_BITS{1'b0}};
        end else if (clear) begin
            pass_r          <= 1'b1;
            fail_addr_r     <= {ADDR_BITS{1'b0}};
            fail_expected_r <= {DATA_BITS{1'b0}};
            fail_actual_r   <= {DATA_BITS{1'b0}};
        end else if (mismatch_s && pass_r) begin
            pass_r          <= 1'b0;
            fail_addr_r     <= cmp_addr;
            fail_expected_r <= cmp_expected;
            fail_actual_r   <= rdata;
        end
    end

    assign mismatch      = mismatch_s;
    assign pass          = pass_r;
    assign fail_addr     = fail_addr_r;
    assign fail_expected = fail_expected_r;
    assign fail_actual   = fail_actual_r;

endmodule : mem_bist_cmp

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes background P ascending, then read-P/write-~P
// ascending, then read-~P descending. All memory-side and status outputs are
// registered from the FSM state, so they trail the state by one cycle; the
// compare slot is carried alongside so it lines up with the memory's
// one-cycle read latency.
// Optional build macro: MEM_BIST_STOP_ON_FAIL_EN ends the run at the first
// miscompare.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int                   ADDR_BITS = 6,
    parameter int                   DATA_BITS = 14,
    parameter logic [DATA_BITS-1:0] PATTERN   = DEFAULT_PATTERN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [DATA_BITS-1:0] fail_expected,
    output logic [DATA_BITS-1:0] fail_actual,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic                 mem_write_en,
    input  logic [DATA_BITS-1:0] mem_rdata
);

`ifdef MEM_BIST_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] ADDR_MAX  = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

    bist_state_e          state_r, next_state_s;
    logic [ADDR_BITS-1:0] addr_r, next_addr_s;
    logic                 phase_r, next_phase_s;   // 0 = R cycle, 1 = C cycle
    logic                 start_acc_s;

    logic                 busy_s, done_s, we_s, cmp_en_s;
    logic [ADDR_BITS-1:0] maddr_s;
    logic [DATA_BITS-1:0] wdata_s, cmp_exp_s;

    logic                 busy_r, done_r, we_r, cmp_en_r;
    logic [ADDR_BITS-1:0] maddr_r, cmp_addr_r;
    logic [DATA_BITS-1:0] wdata_r, cmp_exp_r;

    logic                 mismatch_s;

    // State, address counter and R/C phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= ADDR_ZERO;
            phase_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            addr_r  <= next_addr_s;
            phase_r <= next_phase_s;
        end
    end

    // Next-state logic; phase ends are detected on terminal address values.
    always_comb begin
        next_state_s = state_r;
        next_addr_s  = addr_r;
        next_phase_s = phase_r;
        start_acc_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    start_acc_s  = 1'b1;
                    next_state_s = WR_BG;
                    next_addr_s  = ADDR_ZERO;
                    next_phase_s = 1'b0;
                end else begin
                    next_state_s = state_r;
                end
            end
            WR_BG: begin
                if (addr_r == ADDR_MAX) begin
                    next_state_s = RD_INV;
                    next_addr_s  = ADDR_ZERO;
                    next_phase_s = 1'b0;
                end else begin
                    next_addr_s  = addr_r + ADDR_ONE;
                end
            end
            RD_INV: begin
                if (!phase_r) begin
                    next_phase_s = 1'b1;
                end else begin
                    next_phase_s = 1'b0;
                    if (addr_r == ADDR_MAX) begin
                        next_state_s = RD_DESC;
                        next_addr_s  = ADDR_MAX;
                    end else begin
                        next_addr_s  = addr_r + ADDR_ONE;
                    end
                end
            end
            RD_DESC: begin
                if (!phase_r) begin
                    next_phase_s = 1'b1;
                end else begin
                    next_phase_s = 1'b0;
                    if (addr_r == ADDR_ZERO) begin
                        next_state_s = DONE;
                        next_addr_s  = ADDR_ZERO;
                    end else begin
                        next_addr_s  = addr_r - ADDR_ONE;
                    end
                end
            end
            default: begin
                next_state_s = IDLE;
                next_addr_s  = ADDR_ZERO;
                next_phase_s = 1'b0;
            end
        endcase
        // Early termination: a miscompare can only occur while a run is active.
        if (STOP_ON_FAIL && mismatch_s && (state_r != IDLE) && (state_r != DONE)) begin
            next_state_s = DONE;
            next_addr_s  = ADDR_ZERO;
            next_phase_s = 1'b0;
        end else begin
            next_phase_s = next_phase_s;
        end
    end

    // Decode memory-side controls and the compare slot from the current state.
    always_comb begin
        busy_s    = 1'b0;
        done_s    = 1'b0;
        we_s      = 1'b0;
        cmp_en_s  = 1'b0;
        maddr_s   = ADDR_ZERO;
        wdata_s   = DATA_ZERO;
        cmp_exp_s = DATA_ZERO;
        case (state_r)
            WR_BG: begin
                busy_s  = 1'b1;
                we_s    = 1'b1;
                maddr_s = addr_r;
                wdata_s = PATTERN;
            end
            RD_INV: begin
                busy_s    = 1'b1;
                maddr_s   = addr_r;
                cmp_exp_s = PATTERN;
                if (phase_r) begin
                    we_s     = 1'b1;
                    wdata_s  = ~PATTERN;
                    cmp_en_s = 1'b1;
                end else begin
                    we_s     = 1'b0;
                end
            end
            RD_DESC: begin
                busy_s    = 1'b1;
                maddr_s   = addr_r;
                cmp_exp_s = ~PATTERN;
                cmp_en_s  = phase_r;
            end
            DONE: begin
                done_s = 1'b1;
            end
            IDLE: begin
                done_s = 1'b0;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Output and compare-slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            we_r       <= 1'b0;
            maddr_r    <= ADDR_ZERO;
            wdata_r    <= DATA_ZERO;
            cmp_en_r   <= 1'b0;
            cmp_addr_r <= ADDR_ZERO;
            cmp_exp_r  <= DATA_ZERO;
        end else begin
            busy_r     <= busy_s;
            done_r     <= done_s;
            we_r       <= we_s;
            maddr_r    <= maddr_s;
            wdata_r    <= wdata_s;
            cmp_en_r   <= cmp_en_s;
            cmp_addr_r <= maddr_s;
            cmp_exp_r  <= cmp_exp_s;
        end
    end

    mem_bist_cmp #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_cmp (
        .clk           (clk),
        .rst           (rst),
        .clear         (start_acc_s),
        .cmp_en        (cmp_en_r),
        .cmp_addr      (cmp_addr_r),
        .cmp_expected  (cmp_exp_r),
        .rdata         (mem_rdata),
        .mismatch      (mismatch_s),
        .pass          (pass),
        .fail_addr     (fail_addr),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual)
    );

    assign busy         = busy_r;
    assign done         = done_r;
    assign mem_addr     = maddr_r;
    assign mem_wdata    = wdata_r;
    assign mem_write_en = we_r;

endmodule : mem_bist_ctrl

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a 64x14 registered-address memory
// model that supports per-word stuck-at masks.
module tb_mem_bist_ctrl;

    localparam int AB = 6;
    localparam int DB = 14;
    localparam logic [DB-1:0] P_W  = 14'h2AAA;
    localparam logic [DB-1:0] NP_W = 14'h1555;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, mem_write_en;
    logic [AB-1:0] fail_addr, mem_addr;
    logic [DB-1:0] fail_expected, fail_actual, mem_wdata, mem_rdata;

    logic [DB-1:0] mem [64];
    logic [DB-1:0] sa0 [64];
    logic [DB-1:0] sa1 [64];
    logic [AB-1:0] addr_q = 6'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int edges;

    mem_bist_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_addr     (fail_addr),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_write_en  (mem_write_en),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read address.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_wdata;
        addr_q <= mem_addr;
    end
    assign mem_rdata = (mem[addr_q] & ~sa0[addr_q]) | sa1[addr_q];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 64; i++) begin
            sa0[i] = 14'h0000;
            sa1[i] = 14'h0000;
        end
    endtask

    // Pulse start for one edge, then count edges until done rises.
    // poke_at >= 0 raises start again right after that edge count.
    task automatic run(input int poke_at, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == poke_at);
            if (done) break;
        end
        start = 1'b0;
        if (n >= 1000) $display("FAIL run_timeout: done never rose within 1000 edges");
    endtask

    initial begin
        int bad;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_pass", {31'd0, pass}, 32'd1);
        check_val("rst_fail_addr", {26'd0, fail_addr}, 32'd0);
        check_val("rst_we", {31'd0, mem_write_en}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Healthy memory
        run(-1, edges);
        check_val("ok_len", edges, 32'd321);
        check_val("ok_pass", {31'd0, pass}, 32'd1);
        check_val("ok_busy_done", {31'd0, busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== NP_W) bad++;
        check_val("ok_mem_1555", bad, 32'd0);

`ifndef MEM_BIST_STOP_ON_FAIL_EN
        // Word 0x15 bit 3 stuck-at-0
        sa0[21] = 14'h0008;
        run(-1, edges);
        check_val("sa0_len", edges, 32'd321);
        check_val("sa0_pass", {31'd0, pass}, 32'd0);
        check_val("sa0_addr", {26'd0, fail_addr}, 32'h15);
        check_val("sa0_exp", {18'd0, fail_expected}, {18'd0, P_W});
        check_val("sa0_act", {18'd0, fail_actual}, 32'h2AA2);
        clear_faults();

        // Bit 0 stuck-at-1 at 0x02 and 0x30: first one wins
        sa1[2]  = 14'h0001;
        sa1[48] = 14'h0001;
        run(-1, edges);
        check_val("sa1_len", edges, 32'd321);
        check_val("sa1_pass", {31'd0, pass}, 32'd0);
        check_val("sa1_addr", {26'd0, fail_addr}, 32'h02);
        check_val("sa1_act", {18'd0, fail_actual}, 32'h2AAB);
        clear_faults();
`else
        // Stop on first fail: 0x05 bit 1 stuck-at-0, RD_INV C compare at edge 77
        sa0[5] = 14'h0002;
        run(-1, edges);
        check_val("stop_len", edges, 32'd78);
        check_val("stop_pass", {31'd0, pass}, 32'd0);
        check_val("stop_addr", {26'd0, fail_addr}, 32'h05);
        check_val("stop_act", {18'd0, fail_actual}, 32'h2AA8);
        clear_faults();
`endif

        // Start from DONE clears prior failing result; mid-run start ignored
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_val("clr_pass", {31'd0, pass}, 32'd1);
        check_val("clr_fail_addr", {26'd0, fail_addr}, 32'd0);
        check_val("clr_fail_act", {18'd0, fail_actual}, 32'd0);
        @(posedge clk);
        #1;
        check_val("clr_done_low", {31'd0, done}, 32'd0);
        check_val("clr_busy", {31'd0, busy}, 32'd1);
        // let it finish, then a run with a start poke at cycle 50
        edges = 0;
        while (!done && edges < 1000) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_val("clr_run_done", {31'd0, done}, 32'd1);
        run(50, edges);
        check_val("poke_len", edges, 32'd321);
        check_val("poke_pass", {31'd0, pass}, 32'd1);
        run(-1, edges);
        check_val("rerun_len", edges, 32'd321);

        // Asynchronous reset mid-run at cycle 100 (RD_INV C slot, write active)
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        check_val("pre_rst_we", {31'd0, mem_write_en}, 32'd1);
        check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("async_we", {31'd0, mem_write_en}, 32'd0);
        check_val("async_busy", {31'd0, busy}, 32'd0);
        check_val("async_done", {31'd0, done}, 32'd0);
        check_val("async_addr", {26'd0, mem_addr}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run(-1, edges);
        check_val("post_rst_len", edges, 32'd321);
        check_val("post_rst_pass", {31'd0, pass}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_bist_ctrl
